// File: rtl/bp_be_pipe_fma_sched.sv
// rtl/bp_be_pipe_fma_sched.sv - issue/flush/writeback scheduler for a shared FMA/IMUL pipe
//
// Tracks ops through an external FMA datapath of fma_latency_p stages. IMUL ops ride the
// same shift pipe but retire at stage imul_latency_p-1. Both kinds share one writeback port;
// an IMUL is held off at issue when it would land on the same cycle as an in-flight FMA.
//
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   issue_v_i/issue_ready_o          issue handshake (ready is combinational)
//   issue_imul_i/issue_rd_i/issue_frm_i  op kind, destination, rounding mode
//   flush_i                          kill ops in stages [0, flush_depth_p-1] and the issuing op
//   stage_v_o                        per-stage live valids (datapath stage enables)
//   frm_r_o                          rounding mode of the op in the last FMA stage
//   core_fflags_i                    flags from the datapath, valid with an FMA writeback
//   wb_v_o/wb_imul_o/wb_rd_o/wb_fflags_o  shared writeback port
//   fflags_clr_i/fflags_acc_o        sticky flag accumulator clear / value
module bp_be_pipe_fma_sched #(
  parameter int fma_latency_p   = 4,
  parameter int imul_latency_p  = 3,
  parameter int flush_depth_p   = 2,
  parameter int rd_addr_width_p = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       issue_v_i,
  output logic                       issue_ready_o,
  input  logic                       issue_imul_i,
  input  logic [rd_addr_width_p-1:0] issue_rd_i,
  input  logic [2:0]                 issue_frm_i,
  input  logic                       flush_i,
  output logic [fma_latency_p-1:0]   stage_v_o,
  output logic [2:0]                 frm_r_o,
  input  logic [4:0]                 core_fflags_i,
  output logic                       wb_v_o,
  output logic                       wb_imul_o,
  output logic [rd_addr_width_p-1:0] wb_rd_o,
  output logic [4:0]                 wb_fflags_o,
  input  logic                       fflags_clr_i,
  output logic [4:0]                 fflags_acc_o
);

  localparam int F = fma_latency_p;
  localparam int I = imul_latency_p;
  localparam int D = fma_latency_p - imul_latency_p;

  logic [F-1:0]               v_q, v_d;
  logic [F-1:0]               imul_q, imul_d;
  logic [rd_addr_width_p-1:0] rd_q  [F];
  logic [rd_addr_width_p-1:0] rd_d  [F];
  logic [2:0]                 frm_q [F];
  logic [2:0]                 frm_d [F];
  logic [4:0]                 acc_q, acc_d;
  logic                       fma_wb, imul_wb;

  // An IMUL issued now writes back in I cycles; an FMA sitting in stage D-1 writes back
  // in exactly the same cycle, so that is the only slot that can collide.
  if (D > 0) begin : g_hazard
    assign issue_ready_o = ~(issue_imul_i & v_q[D-1] & ~imul_q[D-1]);
  end else begin : g_no_hazard
    assign issue_ready_o = 1'b1;
  end

  always_comb begin
    v_d[0]    = issue_v_i & issue_ready_o & ~flush_i;
    imul_d[0] = issue_imul_i;
    rd_d[0]   = issue_rd_i;
    frm_d[0]  = issue_frm_i;
    for (int k = 1; k < F; k++) begin
      // Young stages die on flush; IMUL entries retire after their writeback stage.
      v_d[k]    = v_q[k-1]
                & ~(flush_i && ((k - 1) < flush_depth_p))
                & ~(imul_q[k-1] && ((k - 1) >= (I - 1)));
      imul_d[k] = imul_q[k-1];
      rd_d[k]   = rd_q[k-1];
      frm_d[k]  = frm_q[k-1];
    end
  end

  assign fma_wb  = v_q[F-1] & ~imul_q[F-1];
  assign imul_wb = v_q[I-1] & imul_q[I-1];

  assign wb_v_o       = fma_wb | imul_wb;
  assign wb_imul_o    = imul_wb;
  assign wb_rd_o      = imul_wb ? rd_q[I-1] : rd_q[F-1];
  assign wb_fflags_o  = fma_wb ? core_fflags_i : 5'b0;
  assign stage_v_o    = v_q;
  assign frm_r_o      = frm_q[F-1];
  assign fflags_acc_o = acc_q;

  // Clear and a same-cycle FMA writeback leave only the new flags.
  assign acc_d = (fflags_clr_i ? 5'b0 : acc_q) | wb_fflags_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= '0;
      imul_q <= '0;
      acc_q  <= '0;
      for (int k = 0; k < F; k++) begin
        rd_q[k]  <= '0;
        frm_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      imul_q <= imul_d;
      acc_q  <= acc_d;
      for (int k = 0; k < F; k++) begin
        rd_q[k]  <= rd_d[k];
        frm_q[k] <= frm_d[k];
      end
    end
  end

endmodule

// File: tb/tb_bp_be_pipe_fma_sched.sv
// tb/tb_bp_be_pipe_fma_sched.sv - self-checking bench for bp_be_pipe_fma_sched
module tb_bp_be_pipe_fma_sched;

  localparam int F  = 4;
  localparam int I  = 3;
  localparam int FD = 2;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       issue_v_i = 1'b0;
  logic       issue_ready_o;
  logic       issue_imul_i = 1'b0;
  logic [4:0] issue_rd_i = '0;
  logic [2:0] issue_frm_i = '0;
  logic       flush_i = 1'b0;
  logic [3:0] stage_v_o;
  logic [2:0] frm_r_o;
  logic [4:0] core_fflags_i = '0;
  logic       wb_v_o;
  logic       wb_imul_o;
  logic [4:0] wb_rd_o;
  logic [4:0] wb_fflags_o;
  logic       fflags_clr_i = 1'b0;
  logic [4:0] fflags_acc_o;

  bp_be_pipe_fma_sched #(
    .fma_latency_p(F), .imul_latency_p(I), .flush_depth_p(FD), .rd_addr_width_p(5)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .issue_v_i(issue_v_i), .issue_ready_o(issue_ready_o), .issue_imul_i(issue_imul_i),
    .issue_rd_i(issue_rd_i), .issue_frm_i(issue_frm_i), .flush_i(flush_i),
    .stage_v_o(stage_v_o), .frm_r_o(frm_r_o), .core_fflags_i(core_fflags_i),
    .wb_v_o(wb_v_o), .wb_imul_o(wb_imul_o), .wb_rd_o(wb_rd_o), .wb_fflags_o(wb_fflags_o),
    .fflags_clr_i(fflags_clr_i), .fflags_acc_o(fflags_acc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       iv, im;
    logic [4:0] rd;
    logic [2:0] frm;
    logic       fl;
    logic [4:0] ff;
    logic       clr;
    logic       e_rdy;
    logic [3:0] e_sv;
    logic       e_wb, e_wbi;
    logic [4:0] e_rd;
    logic [2:0] e_frm;
    logic [4:0] e_acc;
  } vec_t;

  typedef struct {
    int         issue;
    int         wbc;
    bit         imul;
    logic [4:0] rd;
    logic [2:0] frm;
  } op_t;

  vec_t tbl[$];
  op_t  ops[$];
  int   cyc = 0;
  logic [4:0] m_acc = '0;
  bit   m_rdy, m_fma_wb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input logic iv, im, input logic [4:0] rd, input logic [2:0] frm,
                     input logic fl, input logic [4:0] ff, input logic clr, input logic e_rdy,
                     input logic [3:0] e_sv, input logic e_wb, e_wbi, input logic [4:0] e_rd,
                     input logic [2:0] e_frm, input logic [4:0] e_acc);
    vec_t v;
    v.iv = iv; v.im = im; v.rd = rd; v.frm = frm; v.fl = fl; v.ff = ff; v.clr = clr;
    v.e_rdy = e_rdy; v.e_sv = e_sv; v.e_wb = e_wb; v.e_wbi = e_wbi; v.e_rd = e_rd;
    v.e_frm = e_frm; v.e_acc = e_acc;
    tbl.push_back(v);
  endtask

  // Reference: each live op knows its issue cycle and its writeback cycle.
  task automatic model_check();
    bit         e_wb = 0, e_wbi = 0, frm_known = 0;
    logic [4:0] e_rd = '0;
    logic [3:0] e_sv = '0;
    logic [2:0] e_frm = '0;
    m_rdy = 1;
    foreach (ops[j]) begin
      int k;
      k = cyc - ops[j].issue - 1;
      if (k >= 0 && k < F) e_sv[k] = 1'b1;
      if (ops[j].wbc == cyc) begin
        e_wb = 1; e_wbi = ops[j].imul; e_rd = ops[j].rd;
      end
      if (!ops[j].imul && k == F - 1) begin
        frm_known = 1; e_frm = ops[j].frm;
      end
      if (issue_imul_i && !ops[j].imul && ops[j].wbc == cyc + I) m_rdy = 0;
    end
    m_fma_wb = e_wb && !e_wbi;
    chk("m_ready", issue_ready_o, m_rdy);
    chk("m_stage_v", stage_v_o, e_sv);
    chk("m_wb_v", wb_v_o, e_wb);
    if (e_wb) begin
      chk("m_wb_imul", wb_imul_o, e_wbi);
      chk("m_wb_rd", wb_rd_o, e_rd);
      chk("m_wb_fflags", wb_fflags_o, e_wbi ? 5'b0 : core_fflags_i);
    end
    if (frm_known) chk("m_frm_r", frm_r_o, e_frm);
    chk("m_acc", fflags_acc_o, m_acc);
  endtask

  task automatic model_update();
    m_acc = (fflags_clr_i ? 5'b0 : m_acc) | (m_fma_wb ? core_fflags_i : 5'b0);
    for (int j = ops.size() - 1; j >= 0; j--)
      if (ops[j].wbc == cyc || (flush_i && ops[j].issue >= cyc - FD)) ops.delete(j);
    if (issue_v_i && m_rdy && !flush_i)
      ops.push_back('{cyc, cyc + (issue_imul_i ? I : F), issue_imul_i, issue_rd_i, issue_frm_i});
    cyc++;
  endtask

  task automatic run_cycle(input bit use_tbl, input vec_t v);
    issue_v_i = v.iv; issue_imul_i = v.im; issue_rd_i = v.rd; issue_frm_i = v.frm;
    flush_i = v.fl; core_fflags_i = v.ff; fflags_clr_i = v.clr;
    @(negedge clk_i);
    model_check();
    if (use_tbl) begin
      chk("t_ready", issue_ready_o, v.e_rdy);
      chk("t_stage_v", stage_v_o, v.e_sv);
      chk("t_wb_v", wb_v_o, v.e_wb);
      if (v.e_wb) begin
        chk("t_wb_imul", wb_imul_o, v.e_wbi);
        chk("t_wb_rd", wb_rd_o, v.e_rd);
      end
      if (v.e_sv[3]) chk("t_frm_r", frm_r_o, v.e_frm);
      chk("t_acc", fflags_acc_o, v.e_acc);
    end
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wb_v"}, wb_v_o, 0);
    chk({tag, "_wb_imul"}, wb_imul_o, 0);
    chk({tag, "_wb_rd"}, wb_rd_o, 0);
    chk({tag, "_wb_fflags"}, wb_fflags_o, 0);
    chk({tag, "_stage_v"}, stage_v_o, 0);
    chk({tag, "_frm_r"}, frm_r_o, 0);
    chk({tag, "_acc"}, fflags_acc_o, 0);
    chk({tag, "_ready"}, issue_ready_o, 1);
  endtask

  initial begin
    vec_t v;
    //  iv im rd     frm fl ff      clr rdy sv       wb wbi rd     frm  acc
    add(1, 0, 5'd5,  3, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h00); // 0 FMA rd5
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0001, 0, 0, 5'd0,  0, 5'h00);
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0010, 0, 0, 5'd0,  0, 5'h00);
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0100, 0, 0, 5'd0,  0, 5'h00);
    add(0, 0, 5'd0,  0, 0, 5'h01, 0, 1, 4'b1000, 1, 0, 5'd5,  3, 5'h00); // 4 FMA wb
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h01);
    add(1, 1, 5'd7,  0, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h01); // 6 IMUL rd7
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0001, 0, 0, 5'd0,  0, 5'h01);
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0010, 0, 0, 5'd0,  0, 5'h01);
    add(0, 0, 5'd0,  0, 0, 5'h1f, 0, 1, 4'b0100, 1, 1, 5'd7,  0, 5'h01); // 9 IMUL wb
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h01);
    add(1, 0, 5'd9,  5, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h01); // 11 FMA rd9
    add(1, 1, 5'd10, 0, 0, 5'h00, 0, 0, 4'b0001, 0, 0, 5'd0,  0, 5'h01); // 12 IMUL blocked
    add(1, 1, 5'd10, 0, 0, 5'h00, 0, 1, 4'b0010, 0, 0, 5'd0,  0, 5'h01); // 13 IMUL accepted
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0101, 0, 0, 5'd0,  0, 5'h01);
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b1010, 1, 0, 5'd9,  5, 5'h01); // 15 FMA wb
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0100, 1, 1, 5'd10, 0, 5'h01); // 16 IMUL wb
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h01);
    add(1, 0, 5'd1,  1, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h01); // 18 FMA rd1
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0001, 0, 0, 5'd0,  0, 5'h01);
    add(1, 0, 5'd2,  2, 0, 5'h00, 0, 1, 4'b0010, 0, 0, 5'd0,  0, 5'h01); // 20 FMA rd2
    add(1, 0, 5'd3,  4, 1, 5'h00, 0, 1, 4'b0101, 0, 0, 5'd0,  0, 5'h01); // 21 FMA rd3 + flush
    add(0, 0, 5'd0,  0, 0, 5'h02, 0, 1, 4'b1000, 1, 0, 5'd1,  1, 5'h01); // 22 only rd1 wb
    add(1, 0, 5'd4,  6, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h03); // 23 FMA rd4
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0001, 0, 0, 5'd0,  0, 5'h03);
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0010, 0, 0, 5'd0,  0, 5'h03);
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0100, 0, 0, 5'd0,  0, 5'h03);
    add(0, 0, 5'd0,  0, 0, 5'h10, 1, 1, 4'b1000, 1, 0, 5'd4,  6, 5'h03); // 27 clr + wb
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h10);
    add(0, 0, 5'd0,  0, 0, 5'h00, 1, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h10); // 29 clr alone
    add(0, 0, 5'd0,  0, 0, 5'h00, 0, 1, 4'b0000, 0, 0, 5'd0,  0, 5'h00);

    // Reset state while reset is held, with an IMUL presented.
    issue_v_i = 1; issue_imul_i = 1;
    #12;
    chk_reset_outputs("rst");
    issue_v_i = 0; issue_imul_i = 0;
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;

    foreach (tbl[i]) run_cycle(1, tbl[i]);

    for (int n = 0; n < 400; n++) begin
      v = tbl[0];
      v.iv  = ($urandom_range(0, 9) < 6);
      v.im  = ($urandom_range(0, 9) < 4);
      v.rd  = 5'($urandom);
      v.frm = 3'($urandom);
      v.fl  = ($urandom_range(0, 9) == 0);
      v.ff  = 5'($urandom);
      v.clr = ($urandom_range(0, 19) == 0);
      run_cycle(0, v);
    end

    // Three FMAs in flight, then an asynchronous reset mid-cycle.
    v = tbl[0];
    v.ff = 5'h1f;
    for (int n = 0; n < 3; n++) begin
      v.rd = 5'(n + 20);
      run_cycle(0, v);
    end
    issue_v_i = 1; issue_imul_i = 1; flush_i = 0; fflags_clr_i = 0; core_fflags_i = 5'h1f;
    #2 reset_n_i = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    ops.delete();
    m_acc = '0;
    cyc++;
    v = tbl[1];
    for (int n = 0; n < 8; n++) run_cycle(0, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
